// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore control unit sequencing fetch/decode/execute/memory/writeback
module multicycle_ctrl_fsm #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    state_t st;
    logic   rdy;

    assign rdy   = USE_MEM_READY ? mem_ready : 1'b1;
    assign state = st;

    // state sequencing; illegal_op latches any undecodable opcode until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= FETCH;
            illegal_op <= 1'b0;
        end else begin
            case (st)
                FETCH:  st <= rdy ? DECODE : FETCH;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: st <= MEMADR;
                        OP_RTYPE:     st <= EXEC;
                        OP_BEQ:       st <= BRANCH;
                        OP_J:         st <= JUMP;
                        OP_ADDI:      st <= ADDIEX;
                        default: begin
                            st         <= FETCH;
                            illegal_op <= 1'b1;
                        end
                    endcase
                end
                MEMADR: st <= (opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD:  st <= rdy ? MEMWB : MEMRD;
                MEMWR:  st <= rdy ? FETCH : MEMWR;
                EXEC:   st <= ALUWB;
                ADDIEX: st <= ADDIWB;
                default: st <= FETCH;
            endcase
        end
    end

    // Moore decode of the control word; only the fetch write enables see mem_ready
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (st)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = rdy;
                ir_write  = rdy;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: reg_write = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control unit for the multi-cycle datapath. It is a Moore-style state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It produces the write enables (PC, IR, register file, memory) consumed by the datapath's write-enable registers, plus the mux and ALU selects. It sits directly upstream of the PC/IR/MDR/A/B/ALUOut registers, and its state advances only on the rising clock edge.

Parameters:
USE_MEM_READY, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as constant 1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
opcode  input  6  instr[31:26] taken from the IR output
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  unconditional PC write enable
pc_write_cond  output  1  PC write enable, qualified by ALU zero in the datapath
ir_write  output  1  IR write enable
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_to_reg  output  1  register-file write data select: 0 = ALUOut, 1 = MDR
reg_dst  output  1  destination register select: 0 = rt, 1 = rd
reg_write  output  1  register-file write enable
alu_src_a  output  1  ALU A select: 0 = PC, 1 = A register
alu_src_b  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate
alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded
pc_source  output  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
state  output  4  current state encoding (debug)
illegal_op  output  1  sticky flag, set on an unknown opcode

Behaviour:
- Reset: rst=1 asynchronously forces state=FETCH(0) and illegal_op=0. The state register and illegal_op are the only registers in the block.
- All outputs are decoded from state. In FETCH only, pc_write and ir_write are additionally ANDed with mem_ready (effective mem_ready: forced to 1 when USE_MEM_READY=0). Any output not listed for a state is 0.
- While rst is held, outputs show the FETCH decode: mem_read=1, alu_src_b=01, pc_write=ir_write=mem_ready, everything else 0.
- Opcodes: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
- States, their asserted outputs, and next-state rules:
  - FETCH(0): mem_read, alu_src_b=01, pc_write/ir_write gated by mem_ready. mem_ready -> DECODE; otherwise stay in FETCH.
  - DECODE(1): alu_src_b=11. Next state by opcode: LW/SW -> MEMADR, RTYPE -> EXEC, BEQ -> BRANCH, J -> JUMP, ADDI -> ADDIEX, any other -> FETCH with illegal_op set to 1.
  - MEMADR(2): alu_src_a=1, alu_src_b=10. LW -> MEMRD, SW -> MEMWR.
  - MEMRD(3): mem_read, i_or_d=1. mem_ready -> MEMWB; otherwise stay.
  - MEMWB(4): reg_write, mem_to_reg=1, reg_dst=0. -> FETCH.
  - MEMWR(5): mem_write, i_or_d=1. mem_ready -> FETCH; otherwise stay. mem_write stays high for every wait cycle.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. -> ALUWB.
  - ALUWB(7): reg_write, reg_dst=1, mem_to_reg=0. -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01. -> FETCH.
  - JUMP(9): pc_write, pc_source=10. -> FETCH.
  - ADDIEX(10): alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDIWB.
  - ADDIWB(11): reg_write, reg_dst=0, mem_to_reg=0. -> FETCH.
  - Codes 12-15 (unreachable): all outputs 0; next state FETCH.
- CPI with mem_ready constant 1: LW=5, SW=4, RTYPE=4, ADDI=4, BEQ=3, J=3.
- opcode is sampled only in DECODE and MEMADR. The IR is not rewritten between those states, so opcode is stable there.
- illegal_op stays at 1 until reset. It does not halt sequencing.
- Reset asserted mid-instruction: the FSM returns to FETCH immediately (asynchronously). No pending mem_write or reg_write may appear after rst rises.

Test Plan:
- Reset with rst=1 from t=0, released at 6ns -> state=0, illegal_op=0, mem_read=1, alu_src_b=01. In the first cycle after release with mem_ready=1: pc_write=1 and ir_write=1.
- LW (opcode=100011), mem_ready=1 -> states 0,1,2,3,4,0 on consecutive edges. reg_write=1 with mem_to_reg=1 only in state 4.
- SW with mem_ready low for 3 cycles in MEMWR -> state holds at 5 with mem_write=1 for 4 cycles, then returns to 0. reg_write stays 0 throughout.
- RTYPE, then BEQ, then J -> RTYPE: alu_op=10 in state 6 and reg_dst=1 in state 7. BEQ: pc_write_cond=1 with pc_source=01 in state 8. J: pc_write=1 with pc_source=10 in state 9.
- opcode=111111 -> DECODE goes to FETCH and illegal_op=1. illegal_op remains 1 through a following ADDI (states 0,1,10,11,0) and clears only on rst.
- rst asserted mid-cycle while in MEMWR -> state=0 and mem_write=0 before the next clk edge.
